// File: rtl/out_port_buffer.sv
// out_port_buffer
// Captures processor OUT-port words into a small first-word-fall-through FIFO
// and drains them to a peripheral over a valid/ready handshake. The core is
// never stalled: a word that arrives while the buffer is full and not draining
// is dropped, and the drop is recorded in a sticky flag and a saturating counter.
module out_port_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] outPortData,
  input  logic             outSignalEn,
  output logic [WIDTH-1:0] port_data,
  output logic             port_valid,
  input  logic             port_ready,
  input  logic             ovf_clr,
  output logic [PW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  localparam logic [PW-1:0] PtrOne = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [AW-1:0]    wrIdx;
  logic [AW-1:0]    rdIdx;
  logic             doRead;
  logic             doWrite;
  logic             doDrop;

  // Pointer-derived status and the read/write/drop decisions for this cycle.
  // The MSB of each pointer is a wrap bit, so full and empty are distinguishable.
  always_comb begin
    wrIdx      = wrPtr[AW-1:0];
    rdIdx      = rdPtr[AW-1:0];
    empty      = (wrPtr == rdPtr);
    full       = (wrPtr[PW-1] != rdPtr[PW-1]) && (wrIdx == rdIdx);
    count      = wrPtr - rdPtr;
    port_valid = !empty;
    port_data  = empty ? '0 : mem[rdIdx];
    doRead     = port_valid && port_ready;
    // A read in the same cycle frees a slot, so a full buffer still accepts.
    doWrite    = outSignalEn && (!full || doRead);
    doDrop     = outSignalEn && full && !doRead;
  end

  // Storage array; contents are don't-care after reset, so it has no reset term.
  always_ff @(posedge clk) begin
    if (!reset && doWrite) begin
      mem[wrIdx] <= outPortData;
    end
  end

  // Write and read pointers, wrapping modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + PtrOne;
      if (doRead)  rdPtr <= rdPtr + PtrOne;
    end
  end

  // Drop accounting; a drop in the same cycle as a clear wins and counts as one.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (doDrop) begin
      overflow <= 1'b1;
      if (ovf_clr) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (ovf_clr) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end
  end

endmodule
